// File: rtl/ppe_row_window.sv
// rtl/ppe_row_window.sv - double-buffered row intake, sliding window and row request issue for a partial-sum PE
module ppe_row_window #(
    parameter int PE_ID       = 5,
    parameter int IMEM_ID     = 10,
    parameter int IFMAP_SIZE  = 25,
    parameter int FILTER_SIZE = 5,
    parameter int ROWS_PER_TS = 5,
    parameter int NUM_TS      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IFMAP_SIZE+7:0] in_packet,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [FILTER_SIZE-1:0] win_data,
    output logic [4:0]            win_col,
    output logic [2:0]            win_row,
    output logic                  win_ts,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [IFMAP_SIZE+7:0] req_packet,
    output logic                  ts_done,
    output logic                  all_done,
    output logic                  err
);

    localparam int PKT_W    = IFMAP_SIZE + 8;
    localparam int LAST_COL = IFMAP_SIZE - FILTER_SIZE;

    localparam logic [PKT_W-1:0] REQ_PKT = {4'(IMEM_ID), 4'(PE_ID), {IFMAP_SIZE{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SLIDE,
        S_WAIT_REQ,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IFMAP_SIZE-1:0]  pending_data;
    logic                   pending_valid;
    logic [IFMAP_SIZE-1:0]  active_data;
    logic                   active_valid;
    logic [4:0]             col;
    logic [2:0]             rows_received;
    logic [2:0]             rows_consumed;
    logic [2:0]             req_count;
    logic                   ts;
    logic                   req_outstanding;
    logic                   req_valid_r;
    logic                   ts_done_r;
    logic                   err_r;

    logic [3:0]             pkt_dest;
    logic [3:0]             pkt_op;
    logic                   accept;
    logic                   pkt_good;
    logic                   row_accept;
    logic                   win_hs;
    logic                   row_end;
    logic                   ts_end;
    logic                   transfer;
    logic                   req_hs;
    logic                   req_cond;
    logic                   active_valid_nxt;
    logic                   run_done_nxt;
    logic                   req_busy_nxt;
    logic [IFMAP_SIZE-1:0]  window_shift;

    // Handshake qualifiers and next-state hints shared by the sequential block
    always_comb begin
        pkt_dest         = in_packet[PKT_W-1 -: 4];
        pkt_op           = in_packet[PKT_W-5 -: 4];
        accept           = in_valid && in_ready;
        pkt_good         = (pkt_dest == 4'(PE_ID)) && (pkt_op == 4'd1) && (state != S_DONE);
        row_accept       = accept && pkt_good;
        win_hs           = active_valid && win_ready;
        row_end          = win_hs && (col == 5'(LAST_COL));
        ts_end           = row_end && (rows_consumed == 3'(ROWS_PER_TS - 1));
        // Transfer looks at the current active flag, so a row that just ended
        // leaves a one-cycle bubble before the next row is promoted.
        transfer         = !active_valid && pending_valid;
        req_hs           = req_valid_r && req_ready;
        req_cond         = !req_valid_r && !req_outstanding && !pending_valid
                           && (rows_received != 3'd0)
                           && (rows_received < 3'(ROWS_PER_TS))
                           && (req_count < rows_received)
                           && (state != S_DONE);
        active_valid_nxt = transfer || (active_valid && !row_end);
        run_done_nxt     = (state == S_DONE) || (ts_end && (ts == 1'(NUM_TS - 1)));
        req_busy_nxt     = req_cond || (req_valid_r && !req_hs) || req_hs
                           || (req_outstanding && !row_accept);
    end

    // Output views of the registered state
    always_comb begin
        window_shift = active_data >> col;
        in_ready     = !reset && !pending_valid;
        win_valid    = active_valid;
        win_data     = active_valid ? window_shift[FILTER_SIZE-1:0] : '0;
        win_col      = col;
        win_row      = rows_consumed;
        win_ts       = ts;
        req_valid    = req_valid_r;
        req_packet   = req_valid_r ? REQ_PKT : '0;
        ts_done      = ts_done_r;
        all_done     = (state == S_DONE);
        err          = err_r;
    end

    // Row buffering, window stepping, request issue and run-phase tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            pending_data    <= '0;
            pending_valid   <= 1'b0;
            active_data     <= '0;
            active_valid    <= 1'b0;
            col             <= '0;
            rows_received   <= '0;
            rows_consumed   <= '0;
            req_count       <= '0;
            ts              <= 1'b0;
            req_outstanding <= 1'b0;
            req_valid_r     <= 1'b0;
            ts_done_r       <= 1'b0;
            err_r           <= 1'b0;
        end else begin
            // Pending slot: only written when empty, so accept and transfer never collide
            if (row_accept) begin
                pending_data <= in_packet[IFMAP_SIZE-1:0];
            end
            pending_valid <= row_accept || (pending_valid && !transfer);

            if (transfer) begin
                active_data <= pending_data;
            end
            active_valid <= active_valid_nxt;

            if (transfer || row_end) begin
                col <= '0;
            end else if (win_hs) begin
                col <= col + 5'd1;
            end

            // A row accepted on the same edge as the timestep wrap belongs to the new timestep
            if (ts_end) begin
                rows_received <= {2'b00, row_accept};
            end else if (row_accept) begin
                rows_received <= rows_received + 3'd1;
            end

            if (ts_end) begin
                rows_consumed <= '0;
            end else if (row_end) begin
                rows_consumed <= rows_consumed + 3'd1;
            end

            if (ts_end) begin
                req_count <= '0;
            end else if (req_hs) begin
                req_count <= req_count + 3'd1;
            end

            if (req_hs) begin
                req_outstanding <= 1'b1;
            end else if (row_accept) begin
                req_outstanding <= 1'b0;
            end

            if (req_hs) begin
                req_valid_r <= 1'b0;
            end else if (req_cond) begin
                req_valid_r <= 1'b1;
            end

            ts_done_r <= ts_end;
            if (ts_end && (ts != 1'(NUM_TS - 1))) begin
                ts <= ~ts;
            end

            if (accept && !pkt_good) begin
                err_r <= 1'b1;
            end

            case (state)
                S_DONE: state <= S_DONE;
                default: begin
                    if (run_done_nxt) begin
                        state <= S_DONE;
                    end else if (active_valid_nxt) begin
                        state <= S_SLIDE;
                    end else if (req_busy_nxt) begin
                        state <= S_WAIT_REQ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
